// File: rtl/eth_pkg.sv
// Shared types for the Ethernet TX arbiter: byte format with SOP/EOP flags and FSM states.
package eth_pkg;

    localparam int unsigned SOP_BIT    = 9;
    localparam int unsigned EOP_BIT    = 8;
    localparam int unsigned ETH_BYTE_W = 10;

    typedef logic [ETH_BYTE_W-1:0] eth_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND0,
        SEND1
    } arb_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_pkt_fifo.sv
// Store-and-forward packet buffer: a packet becomes readable only once its EOP is written;
// partial packets are rolled back to the start pointer on overflow or a premature SOP.
module eth_pkt_fifo
    import eth_pkg::*;
#(
    parameter int unsigned Depth = 2048
) (
    input  logic      clk,
    input  logic      rst,
    input  eth_byte_t wr_byte,
    input  logic      wr_valid,
    input  logic      rd_en,
    output eth_byte_t rd_data,
    output logic      rd_valid,
    output logic      pkt_avail,
    output logic      pkt_done,
    output logic      drop
);

    localparam int unsigned AW = $clog2(Depth);
    typedef logic [AW:0] ptr_t;

    eth_byte_t mem [Depth];

    ptr_t        wr_ptr_q, wr_ptr_d, start_q, start_d, rd_ptr_q, wp;
    logic        in_pkt_q, in_pkt_d, drop_d, commit, mem_we;
    logic [AW:0] cnt_q;

    function automatic logic is_full(input ptr_t p, input ptr_t r);
        return (p[AW-1:0] == r[AW-1:0]) && (p[AW] != r[AW]);
    endfunction

    // Outside a packet wr_ptr equals start, so an SOP always writes from the start pointer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        start_d  = start_q;
        in_pkt_d = in_pkt_q;
        drop_d   = 1'b0;
        commit   = 1'b0;
        mem_we   = 1'b0;
        wp       = wr_ptr_q;
        if (wr_valid && (wr_byte[SOP_BIT] || in_pkt_q)) begin
            wp     = wr_byte[SOP_BIT] ? start_q : wr_ptr_q;
            drop_d = wr_byte[SOP_BIT] && in_pkt_q;
            if (is_full(wp, rd_ptr_q)) begin
                drop_d   = 1'b1;
                wr_ptr_d = start_q;
                in_pkt_d = 1'b0;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wp + 1'b1;
                in_pkt_d = !wr_byte[EOP_BIT];
                if (wr_byte[EOP_BIT]) begin
                    start_d = wp + 1'b1;
                    commit  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wp[AW-1:0]] <= wr_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            start_q  <= '0;
            in_pkt_q <= 1'b0;
            drop     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            start_q  <= start_d;
            in_pkt_q <= in_pkt_d;
            drop     <= drop_d;
            if (commit && !pkt_done) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!commit && pkt_done) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_ptr_q <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data  <= mem[rd_ptr_q[AW-1:0]];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign pkt_done  = rd_valid && rd_data[EOP_BIT];
    assign pkt_avail = (cnt_q != '0);

endmodule

// File: rtl/eth_tx_arb.sv
// Packet-level arbiter feeding eth_tx from two buffered sources (test pattern, loopback).
// Optional saturating statistics counters are enabled with ETH_TX_ARB_STATS_EN.
module eth_tx_arb
    import eth_pkg::*;
#(
    parameter int unsigned gDepth = 2048,
    parameter bit          gRr_En = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  eth_byte_t   Src0_Byte,
    input  logic        Src0_Valid,
    input  eth_byte_t   Src1_Byte,
    input  logic        Src1_Valid,
    input  logic        Tx_Ready,
    output eth_byte_t   Eth_Byte,
    output logic        Eth_Byte_Valid,
    output logic [1:0]  Grant,
    output logic        Src0_Drop,
    output logic        Src1_Drop
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [15:0] Pkt_Cnt0,
    output logic [15:0] Pkt_Cnt1,
    output logic [15:0] Drop_Cnt0,
    output logic [15:0] Drop_Cnt1
`endif
);

    arb_state_t state_q, state_d;
    logic       rr_q, rr_d;
    logic       rd_en0, rd_en1, rd_valid0, rd_valid1;
    logic       avail0, avail1, done0, done1;
    eth_byte_t  rd_data0, rd_data1;

    eth_pkt_fifo #(.Depth(gDepth)) u_fifo0 (
        .clk      (Clk),
        .rst      (Rst),
        .wr_byte  (Src0_Byte),
        .wr_valid (Src0_Valid),
        .rd_en    (rd_en0),
        .rd_data  (rd_data0),
        .rd_valid (rd_valid0),
        .pkt_avail(avail0),
        .pkt_done (done0),
        .drop     (Src0_Drop)
    );

    eth_pkt_fifo #(.Depth(gDepth)) u_fifo1 (
        .clk      (Clk),
        .rst      (Rst),
        .wr_byte  (Src1_Byte),
        .wr_valid (Src1_Valid),
        .rd_en    (rd_en1),
        .rd_data  (rd_data1),
        .rd_valid (rd_valid1),
        .pkt_avail(avail1),
        .pkt_done (done1),
        .drop     (Src1_Drop)
    );

    // rr_q = 1 means src1 wins the next tie; it points away from the source last served.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        rd_en0  = 1'b0;
        rd_en1  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Tx_Ready && (avail0 || avail1)) begin
                    if (avail0 && (!avail1 || !gRr_En || !rr_q)) begin
                        state_d = SEND0;
                        rr_d    = 1'b1;
                    end else begin
                        state_d = SEND1;
                        rr_d    = 1'b0;
                    end
                end
            end
            // Stop reading once the EOP byte sits in the read register.
            SEND0: begin
                if (done0) state_d = IDLE;
                else       rd_en0  = 1'b1;
            end
            SEND1: begin
                if (done1) state_d = IDLE;
                else       rd_en1  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        Grant          = {state_q == SEND1, state_q == SEND0};
        Eth_Byte_Valid = (Grant[0] && rd_valid0) || (Grant[1] && rd_valid1);
        Eth_Byte       = '0;
        if (Grant[0] && rd_valid0) Eth_Byte = rd_data0;
        if (Grant[1] && rd_valid1) Eth_Byte = rd_data1;
    end

`ifdef ETH_TX_ARB_STATS_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Pkt_Cnt0  <= '0;
            Pkt_Cnt1  <= '0;
            Drop_Cnt0 <= '0;
            Drop_Cnt1 <= '0;
        end else begin
            if (done0)     Pkt_Cnt0  <= sat_inc(Pkt_Cnt0);
            if (done1)     Pkt_Cnt1  <= sat_inc(Pkt_Cnt1);
            if (Src0_Drop) Drop_Cnt0 <= sat_inc(Drop_Cnt0);
            if (Src1_Drop) Drop_Cnt1 <= sat_inc(Drop_Cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// Scoreboard bench for eth_tx_arb: drivers queue expected output bytes, a monitor pops and checks.
module tb_eth_tx_arb;
    import eth_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst;
    eth_byte_t  Src0_Byte, Src1_Byte, Eth_Byte;
    logic       Src0_Valid, Src1_Valid, Tx_Ready, Eth_Byte_Valid;
    logic [1:0] Grant;
    logic       Src0_Drop, Src1_Drop;
`ifdef ETH_TX_ARB_STATS_EN
    logic [15:0] Pkt_Cnt0, Pkt_Cnt1, Drop_Cnt0, Drop_Cnt1;
`endif

    always #5 Clk = ~Clk;

    eth_tx_arb #(.gDepth(2048), .gRr_En(1'b1)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Src0_Byte     (Src0_Byte),
        .Src0_Valid    (Src0_Valid),
        .Src1_Byte     (Src1_Byte),
        .Src1_Valid    (Src1_Valid),
        .Tx_Ready      (Tx_Ready),
        .Eth_Byte      (Eth_Byte),
        .Eth_Byte_Valid(Eth_Byte_Valid),
        .Grant         (Grant),
        .Src0_Drop     (Src0_Drop),
        .Src1_Drop     (Src1_Drop)
`ifdef ETH_TX_ARB_STATS_EN
        ,
        .Pkt_Cnt0      (Pkt_Cnt0),
        .Pkt_Cnt1      (Pkt_Cnt1),
        .Drop_Cnt0     (Drop_Cnt0),
        .Drop_Cnt1     (Drop_Cnt1)
`endif
    );

    typedef struct packed {
        eth_byte_t  b;
        logic [1:0] g;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   drops0   = 0;
    int   drops1   = 0;
    bit   expect_quiet = 1'b0;
    bit   in_out   = 1'b0;
    bit   prev_eop = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic eth_byte_t mk(input int i, input int len, input logic [7:0] seed,
                                     input bit eop_en);
        logic [7:0] d;
        d = seed + 8'(i * 37);
        return {(i == 0), (eop_en && (i == len - 1)), d};
    endfunction

    task automatic push_exp(input int src, input int len, input logic [7:0] seed);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{b: mk(i, len, seed, 1'b1), g: (src == 0) ? 2'b01 : 2'b10});
        end
    endtask

    task automatic send_pkt(input int src, input int len, input int spacing,
                            input logic [7:0] seed, input bit eop_en);
        eth_byte_t b;
        for (int i = 0; i < len; i++) begin
            @(negedge Clk);
            b = mk(i, len, seed, eop_en);
            if (src == 0) begin
                Src0_Byte  = b;
                Src0_Valid = 1'b1;
            end else begin
                Src1_Byte  = b;
                Src1_Valid = 1'b1;
            end
            if (b[EOP_BIT]) expect_quiet = 1'b0;
            for (int k = 1; k < spacing; k++) begin
                @(negedge Clk);
                if (src == 0) Src0_Valid = 1'b0;
                else          Src1_Valid = 1'b0;
            end
        end
        @(negedge Clk);
        if (src == 0) Src0_Valid = 1'b0;
        else          Src1_Valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge Clk);
            c++;
        end
        check(name, exp_q.size(), 0);
        repeat (4) @(negedge Clk);
    endtask

    // Monitor: every valid output byte must match the head of the scoreboard.
    always @(negedge Clk) begin
        exp_t e;
        if (Rst) begin
            in_out   = 1'b0;
            prev_eop = 1'b0;
        end else begin
            if (Src0_Drop) drops0++;
            if (Src1_Drop) drops1++;
            if (Eth_Byte_Valid) begin
                if (expect_quiet) check("output_before_eop", Eth_Byte_Valid, 1'b0);
                if (prev_eop)     check("interpacket_gap", Eth_Byte_Valid, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {1'b1, Eth_Byte}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("eth_byte", Eth_Byte, e.b);
                    check("grant", Grant, e.g);
                end
                in_out   = !Eth_Byte[EOP_BIT];
                prev_eop = Eth_Byte[EOP_BIT];
            end else begin
                if (in_out) check("valid_consecutive", Eth_Byte_Valid, 1'b1);
                in_out   = 1'b0;
                prev_eop = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst        = 1'b1;
        Src0_Byte  = '0;
        Src1_Byte  = '0;
        Src0_Valid = 1'b0;
        Src1_Valid = 1'b0;
        Tx_Ready   = 1'b1;
        repeat (3) @(negedge Clk);
        check("reset_valid", Eth_Byte_Valid, 1'b0);
        check("reset_byte", Eth_Byte, 0);
        check("reset_grant", Grant, 2'b00);
        check("reset_drops", {Src0_Drop, Src1_Drop}, 2'b00);
`ifdef ETH_TX_ARB_STATS_EN
        check("reset_pkt_cnt0", Pkt_Cnt0, 0);
        check("reset_drop_cnt1", Drop_Cnt1, 0);
`endif
        Rst = 1'b0;

        // 64-byte packet on src0
        push_exp(0, 64, 8'h10);
        send_pkt(0, 64, 1, 8'h10, 1'b1);
        drain("drain_t1", 200);

        // 60-byte packet on src1 at RMII rate; nothing may leave before EOP is buffered
        push_exp(1, 60, 8'h80);
        expect_quiet = 1'b1;
        send_pkt(1, 60, 4, 8'h80, 1'b1);
        drain("drain_t2", 200);

        // Simultaneous completion: src1 was last served, so src0 wins the tie
        push_exp(0, 20, 8'h21);
        push_exp(1, 20, 8'h41);
        fork
            send_pkt(0, 20, 1, 8'h21, 1'b1);
            send_pkt(1, 20, 1, 8'h41, 1'b1);
        join
        drain("drain_t3a", 200);
        // src0 alone, then another tie: src1 is now the source not last served
        push_exp(0, 4, 8'h55);
        send_pkt(0, 4, 1, 8'h55, 1'b1);
        drain("drain_t3b", 100);
        push_exp(1, 20, 8'h61);
        push_exp(0, 20, 8'h71);
        fork
            send_pkt(0, 20, 1, 8'h71, 1'b1);
            send_pkt(1, 20, 1, 8'h61, 1'b1);
        join
        drain("drain_t3c", 200);
        check("drops0_before_t4", drops0, 0);
        check("drops1_before_t4", drops1, 0);

        // Overflow: 2049 bytes with no EOP, then a normal 10-byte packet
        send_pkt(0, 2049, 1, 8'h03, 1'b0);
        repeat (10) @(negedge Clk);
        check("src0_drop_overflow", drops0, 1);
        push_exp(0, 10, 8'hA0);
        send_pkt(0, 10, 1, 8'hA0, 1'b1);
        drain("drain_t4", 100);

        // SOP after 5 bytes aborts the first src1 packet
        send_pkt(1, 5, 1, 8'hB0, 1'b0);
        push_exp(1, 8, 8'hC0);
        send_pkt(1, 8, 1, 8'hC0, 1'b1);
        drain("drain_t5", 100);
        check("src1_drop_sop", drops1, 1);
        check("src0_drop_total", drops0, 1);
`ifdef ETH_TX_ARB_STATS_EN
        check("pkt_cnt0", Pkt_Cnt0, 5);
        check("pkt_cnt1", Pkt_Cnt1, 4);
        check("drop_cnt0", Drop_Cnt0, 1);
        check("drop_cnt1", Drop_Cnt1, 1);
`endif

        // Tx_Ready gating, grant/data latency, then reset mid-send
        Tx_Ready = 1'b0;
        push_exp(0, 20, 8'hD0);
        send_pkt(0, 20, 1, 8'hD0, 1'b1);
        repeat (10) @(negedge Clk);
        check("not_ready_grant", Grant, 2'b00);
        check("not_ready_valid", Eth_Byte_Valid, 1'b0);
        Tx_Ready = 1'b1;
        @(negedge Clk);
        check("ready_grant_latency", Grant, 2'b01);
        check("ready_valid_latency0", Eth_Byte_Valid, 1'b0);
        @(negedge Clk);
        check("ready_valid_latency1", Eth_Byte_Valid, 1'b1);
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("rst_mid_valid", Eth_Byte_Valid, 1'b0);
        check("rst_mid_grant", Grant, 2'b00);
        check("rst_mid_byte", Eth_Byte, 0);
        exp_q.delete();
        repeat (2) @(negedge Clk);
`ifdef ETH_TX_ARB_STATS_EN
        check("rst_pkt_cnt0", Pkt_Cnt0, 0);
`endif
        Rst = 1'b0;
        repeat (10) @(negedge Clk);
        check("post_reset_idle", {Grant, Eth_Byte_Valid}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
